// File: rtl/exec_unit.sv
// exec_unit: single-issue integer execute stage with 1-cycle ALU ops and a radix-2 restoring divider.
// Optional saturating add/sub is compiled in when EXEC_UNIT_SAT_EN is defined.
module exec_unit #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      op_i,
  input  logic [AW-1:0]   dest_i,
  input  logic [AW-1:0]   dest2_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            cin_i,
  output logic            wb_valid_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      psw_o,
  output logic            illegal_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: a request transfers on a rising edge where in_valid_i && in_ready_o;
  // in_ready_o is high only in IDLE and requests are ignored otherwise.

  localparam int NB = XLEN / 8;
  localparam int NH = XLEN / 16;
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_BSW = 4'd5, OP_BSH = 4'd6, OP_HSW = 4'd7,
                         OP_DIVU = 4'd8, OP_DIV = 4'd9;
`ifdef EXEC_UNIT_SAT_EN
  localparam logic [3:0] OP_SATADD = 4'd10, OP_SATSUB = 4'd11;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, DIV_RUN = 2'd1, WB_Q = 2'd2, WB_R = 2'd3} state_t;
  state_t state_q, state_d;

  logic            accept, is_div, div_zero, div_last;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] div_quo_q, div_rem_q, div_dvs_q;
  logic            neg_q_q, neg_r_q, div_ov_q;
  logic [AW-1:0]   dst_q_q, dst_r_q;
  logic [XLEN:0]   rem_sh, trial;
  logic [XLEN-1:0] quo_out, rem_out;

  assign in_ready_o  = (state_q == IDLE);
  assign dbg_state_o = state_q;
  assign accept      = in_valid_i && in_ready_o;
  assign is_div      = (op_i == OP_DIVU) || (op_i == OP_DIV);
  assign div_zero    = (src1_i == '0);
  assign div_last    = (cnt_q == CW'(XLEN - 1));

  // Divider step: shift the next dividend bit into the partial remainder and try a subtract.
  assign rem_sh  = {div_rem_q, div_quo_q[XLEN-1]};
  assign trial   = rem_sh - {1'b0, div_dvs_q};
  assign quo_out = neg_q_q ? -div_quo_q : div_quo_q;
  assign rem_out = neg_r_q ? -div_rem_q : div_rem_q;

  // ALU arithmetic
  logic            cin_add, add_ov, sub_ov;
  logic [XLEN:0]   add_r, sub_r;
  assign cin_add = cin_i && (op_i == OP_ADD);
  assign add_r   = {1'b0, src2_i} + {1'b0, src1_i} + {{XLEN{1'b0}}, cin_add};
  assign sub_r   = {1'b0, src2_i} - {1'b0, src1_i};
  assign add_ov  = (src2_i[XLEN-1] == src1_i[XLEN-1]) && (add_r[XLEN-1] != src2_i[XLEN-1]);
  assign sub_ov  = (src2_i[XLEN-1] != src1_i[XLEN-1]) && (sub_r[XLEN-1] != src2_i[XLEN-1]);

  logic [XLEN-1:0] bsw, bsh, hsw;
  logic            any_b0, any_h0, bsh_cy;
  always_comb begin
    bsw = '0;
    bsh = '0;
    hsw = '0;
    any_b0 = 1'b0;
    any_h0 = 1'b0;
    for (int i = 0; i < NB; i++) begin
      bsw[8*i +: 8] = src2_i[XLEN-8-8*i +: 8];
      any_b0 = any_b0 | (src2_i[8*i +: 8] == 8'd0);
    end
    for (int i = 0; i < NH; i++) begin
      bsh[16*i +: 16] = {src2_i[16*i +: 8], src2_i[16*i+8 +: 8]};
      hsw[16*i +: 16] = src2_i[XLEN-16-16*i +: 16];
      any_h0 = any_h0 | (src2_i[16*i +: 16] == 16'd0);
    end
    bsh_cy = (src2_i[7:0] == 8'd0) || (src2_i[15:8] == 8'd0);
  end

  logic [XLEN-1:0] res, res_out;
  logic            cy_n, ov_n, s_n, z_n, z_low, legal, sat_hit;
  always_comb begin
    res = '0;
    res_out = '0;
    cy_n = psw_o[3];
    ov_n = 1'b0;
    z_low = 1'b0;
    legal = 1'b1;
    sat_hit = 1'b0;
    case (op_i)
      OP_ADD: begin res = add_r[XLEN-1:0]; cy_n = add_r[XLEN]; ov_n = add_ov; end
      OP_SUB: begin res = sub_r[XLEN-1:0]; cy_n = sub_r[XLEN]; ov_n = sub_ov; end
      OP_AND: res = src2_i & src1_i;
      OP_OR:  res = src2_i | src1_i;
      OP_XOR: res = src2_i ^ src1_i;
      OP_BSW: begin res = bsw; cy_n = any_b0; end
      OP_BSH: begin res = bsh; cy_n = bsh_cy; z_low = 1'b1; end
      OP_HSW: begin res = hsw; cy_n = any_h0; end
      OP_DIVU, OP_DIV: res = '0;
`ifdef EXEC_UNIT_SAT_EN
      OP_SATADD: begin res = add_r[XLEN-1:0]; cy_n = add_r[XLEN]; ov_n = add_ov; sat_hit = add_ov; end
      OP_SATSUB: begin res = sub_r[XLEN-1:0]; cy_n = sub_r[XLEN]; ov_n = sub_ov; sat_hit = sub_ov; end
`endif
      default: legal = 1'b0;
    endcase
    // Flags describe the unclamped result; only the written data saturates.
    s_n = res[XLEN-1];
    z_n = z_low ? (res[15:0] == 16'd0) : (res == '0);
    res_out = res;
    if (sat_hit) res_out = src2_i[XLEN-1] ? SMIN : ~SMIN;
  end

  logic            sgn, s2_neg, s1_neg;
  logic [XLEN-1:0] mag1, mag2;
  always_comb begin
    sgn = (op_i == OP_DIV);
    s2_neg = sgn && src2_i[XLEN-1];
    s1_neg = sgn && src1_i[XLEN-1];
    mag2 = s2_neg ? -src2_i : src2_i;
    mag1 = s1_neg ? -src1_i : src1_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_div && !div_zero) state_d = DIV_RUN;
      DIV_RUN: if (div_last) state_d = WB_Q;
      WB_Q:    state_d = WB_R;
      WB_R:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_o <= 1'b0;
      wb_addr_o  <= '0;
      wb_data_o  <= '0;
      psw_o      <= '0;
      illegal_o  <= 1'b0;
      cnt_q      <= '0;
      div_quo_q  <= '0;
      div_rem_q  <= '0;
      div_dvs_q  <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_ov_q   <= 1'b0;
      dst_q_q    <= '0;
      dst_r_q    <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      illegal_o  <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (is_div) begin
            if (div_zero) begin
              psw_o[2] <= 1'b1;
            end else begin
              div_quo_q <= mag2;
              div_rem_q <= '0;
              div_dvs_q <= mag1;
              cnt_q     <= '0;
              neg_q_q   <= s2_neg ^ s1_neg;
              neg_r_q   <= s2_neg;
              div_ov_q  <= sgn && (src2_i == SMIN) && (src1_i == '1);
              dst_q_q   <= dest_i;
              dst_r_q   <= dest2_i;
            end
          end else if (!legal) begin
            illegal_o <= 1'b1;
          end else begin
            wb_valid_o <= (dest_i != '0);
            wb_addr_o  <= dest_i;
            wb_data_o  <= res_out;
            psw_o      <= {psw_o[4] | sat_hit, cy_n, ov_n, s_n, z_n};
          end
        end
        DIV_RUN: begin
          if (!trial[XLEN]) div_rem_q <= trial[XLEN-1:0];
          else              div_rem_q <= rem_sh[XLEN-1:0];
          div_quo_q <= {div_quo_q[XLEN-2:0], ~trial[XLEN]};
          cnt_q     <= cnt_q + 1'b1;
        end
        WB_Q: begin
          wb_valid_o <= (dst_q_q != '0);
          wb_addr_o  <= dst_q_q;
          wb_data_o  <= quo_out;
          psw_o      <= {psw_o[4], psw_o[3], div_ov_q, quo_out[XLEN-1], quo_out == '0};
        end
        WB_R: begin
          wb_valid_o <= (dst_r_q != '0);
          wb_addr_o  <= dst_r_q;
          wb_data_o  <= rem_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit (XLEN=32): table of single-cycle ops plus divide, divide-by-zero and reset-abort sequences.
module tb_exec_unit;
  localparam int XLEN = 32;
  localparam int AW = 5;
  localparam int W = AW + XLEN;

  logic            clk, rst_n, in_valid_i, in_ready_o, cin_i;
  logic [3:0]      op_i;
  logic [AW-1:0]   dest_i, dest2_i, wb_addr_o;
  logic [XLEN-1:0] src1_i, src2_i, wb_data_o;
  logic            wb_valid_o, illegal_o;
  logic [4:0]      psw_o;
  logic [1:0]      dbg_state_o;

  exec_unit #(.XLEN(XLEN), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .dest_i(dest_i), .dest2_i(dest2_i), .src1_i(src1_i), .src2_i(src2_i),
    .cin_i(cin_i), .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .psw_o(psw_o), .illegal_o(illegal_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every write-back strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (wb_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wb_unexpected: got %0h:%0h expected none", wb_addr_o, wb_data_o);
      end else begin
        check("wb", {27'd0, wb_addr_o, wb_data_o}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  // drivers
  task automatic drive(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic cin, input logic [4:0] d, input logic [4:0] d2);
    op_i = op; src1_i = s1; src2_i = s2; cin_i = cin; dest_i = d; dest2_i = d2;
    in_valid_i = 1'b1;
  endtask

  task automatic run_div(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [4:0] d, input logic [4:0] d2, input logic [31:0] q,
                         input logic [31:0] r, input logic [2:0] flags, input string name);
    int low, qcyc, k;
    @(negedge clk);
    drive(op, s1, s2, 1'b0, d, d2);
    exp_q.push_back({d, q});
    exp_q.push_back({d2, r});
    @(negedge clk);
    // keep a competing request pending while busy; it must be ignored
    drive(4'd0, 32'd1, 32'd1, 1'b0, 5'd20, 5'd0);
    low = 0; qcyc = -1; k = 0;
    while (k < 100) begin
      if (k == 5) in_valid_i = 1'b0;
      if (wb_valid_o && wb_addr_o == d && qcyc < 0) qcyc = k;
      if (in_ready_o) break;
      low++; k++;
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    check({name, "_busy_cycles"}, 64'(low), 64'd34);
    check({name, "_quo_cycle"}, 64'(qcyc), 64'd33);
    check({name, "_flags"}, {61'd0, psw_o[2:0]}, {61'd0, flags});
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] s1, s2;
    logic        cin;
    logic [4:0]  d;
    logic        wb;
    logic [31:0] data;
    logic [4:0]  psw;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; in_valid_i = 1'b0; op_i = '0; src1_i = '0; src2_i = '0;
    cin_i = 1'b0; dest_i = '0; dest2_i = '0;

    //            op     src1          src2          cin  d    wb  data          psw       ill
    vecs.push_back('{4'd0, 32'h00000001, 32'h7FFFFFFF, 1'b0, 5'd5,  1'b1, 32'h80000000, 5'b00110, 1'b0});
    vecs.push_back('{4'd1, 32'h00000001, 32'h00000000, 1'b0, 5'd6,  1'b1, 32'hFFFFFFFF, 5'b01010, 1'b0});
    vecs.push_back('{4'd2, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 5'd7,  1'b1, 32'h00000000, 5'b01001, 1'b0});
    vecs.push_back('{4'd3, 32'h0000000F, 32'hF0000000, 1'b0, 5'd8,  1'b1, 32'hF000000F, 5'b01010, 1'b0});
    vecs.push_back('{4'd4, 32'h12345678, 32'h12345678, 1'b0, 5'd0,  1'b0, 32'h00000000, 5'b01001, 1'b0});
    vecs.push_back('{4'd0, 32'h00000001, 32'hFFFFFFFF, 1'b1, 5'd9,  1'b1, 32'h00000001, 5'b01000, 1'b0});
    vecs.push_back('{4'd5, 32'h00000000, 32'h11223344, 1'b0, 5'd10, 1'b1, 32'h44332211, 5'b00000, 1'b0});
    vecs.push_back('{4'd5, 32'h00000000, 32'h00AB0000, 1'b0, 5'd11, 1'b1, 32'h0000AB00, 5'b01000, 1'b0});
    vecs.push_back('{4'd6, 32'h00000000, 32'hAABB00CC, 1'b0, 5'd12, 1'b1, 32'hBBAACC00, 5'b01010, 1'b0});
    vecs.push_back('{4'd6, 32'h00000000, 32'h12340000, 1'b0, 5'd13, 1'b1, 32'h34120000, 5'b01001, 1'b0});
    vecs.push_back('{4'd7, 32'h00000000, 32'h1234ABCD, 1'b0, 5'd14, 1'b1, 32'hABCD1234, 5'b00010, 1'b0});
    vecs.push_back('{4'd7, 32'h00000000, 32'h00000000, 1'b0, 5'd15, 1'b1, 32'h00000000, 5'b01001, 1'b0});
    vecs.push_back('{4'd1, 32'h00000001, 32'h80000000, 1'b0, 5'd16, 1'b1, 32'h7FFFFFFF, 5'b00100, 1'b0});
    vecs.push_back('{4'd0, 32'h00000003, 32'h00000005, 1'b0, 5'd17, 1'b1, 32'h00000008, 5'b00000, 1'b0});
    vecs.push_back('{4'd1, 32'h00000005, 32'h00000005, 1'b0, 5'd18, 1'b1, 32'h00000000, 5'b00001, 1'b0});
    vecs.push_back('{4'd0, 32'h00000002, 32'h00000001, 1'b1, 5'd19, 1'b1, 32'h00000004, 5'b00000, 1'b0});
    vecs.push_back('{4'd12, 32'h00000001, 32'h00000001, 1'b0, 5'd20, 1'b0, 32'h00000000, 5'b00000, 1'b1});
`ifdef EXEC_UNIT_SAT_EN
    vecs.push_back('{4'd10, 32'h00000001, 32'h7FFFFFFF, 1'b0, 5'd21, 1'b1, 32'h7FFFFFFF, 5'b10110, 1'b0});
    vecs.push_back('{4'd11, 32'h00000001, 32'h80000000, 1'b0, 5'd22, 1'b1, 32'h80000000, 5'b10100, 1'b0});
`else
    vecs.push_back('{4'd10, 32'h00000001, 32'h7FFFFFFF, 1'b0, 5'd21, 1'b0, 32'h00000000, 5'b00000, 1'b1});
    vecs.push_back('{4'd11, 32'h00000001, 32'h80000000, 1'b0, 5'd22, 1'b0, 32'h00000000, 5'b00000, 1'b1});
`endif

    // reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", {52'd0, wb_valid_o, wb_addr_o, psw_o, illegal_o}, 64'd0);
    check("rst_data", {32'd0, wb_data_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {63'd0, in_ready_o}, 64'd1);

    // table-driven single-cycle ops
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].cin, vecs[i].d, 5'd0);
      if (vecs[i].wb) exp_q.push_back({vecs[i].d, vecs[i].data});
      @(negedge clk);
      in_valid_i = 1'b0;
      check($sformatf("vec%0d_psw", i), {59'd0, psw_o}, {59'd0, vecs[i].psw});
      check($sformatf("vec%0d_illegal", i), {63'd0, illegal_o}, {63'd0, vecs[i].ill});
      check($sformatf("vec%0d_ready", i), {63'd0, in_ready_o}, 64'd1);
    end

    // back-to-back acceptance
    @(negedge clk);
    drive(4'd0, 32'd1, 32'd1, 1'b0, 5'd1, 5'd0);
    exp_q.push_back({5'd1, 32'd2});
    @(negedge clk);
    check("b2b_ready", {63'd0, in_ready_o}, 64'd1);
    drive(4'd1, 32'd3, 32'd10, 1'b0, 5'd2, 5'd0);
    exp_q.push_back({5'd2, 32'd7});
    @(negedge clk);
    in_valid_i = 1'b0;

    // divides
    run_div(4'd9, 32'h00000002, 32'hFFFFFFF9, 5'd3, 5'd4, 32'hFFFFFFFD, 32'hFFFFFFFF, 3'b010, "div_neg");
    run_div(4'd9, 32'hFFFFFFFF, 32'h80000000, 5'd21, 5'd22, 32'h80000000, 32'h00000000, 3'b110, "div_ovf");
    run_div(4'd8, 32'h00000010, 32'hFFFFFFFF, 5'd23, 5'd23, 32'h0FFFFFFF, 32'h0000000F, 3'b000, "divu_same");
    run_div(4'd9, 32'hFFFFFFFE, 32'h00000007, 5'd24, 5'd25, 32'hFFFFFFFD, 32'h00000001, 3'b010, "div_pos_neg");

    // fresh reset clears sticky state, then divide by zero
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(4'd8, 32'd0, 32'd123, 1'b0, 5'd26, 5'd27);
    @(negedge clk);
    in_valid_i = 1'b0;
    check("divz_ready", {63'd0, in_ready_o}, 64'd1);
    check("divz_psw", {59'd0, psw_o}, 64'b00100);
    check("divz_state", {62'd0, dbg_state_o}, 64'd0);

    // reset during DIV_RUN aborts the divide
    @(negedge clk);
    drive(4'd8, 32'd7, 32'd100, 1'b0, 5'd27, 5'd28);
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_in_run", {62'd0, dbg_state_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {52'd0, wb_valid_o, wb_addr_o, psw_o, illegal_o}, 64'd0);
    check("abort_data", {32'd0, wb_data_o}, 64'd0);
    check("abort_state", {62'd0, dbg_state_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_ready", {63'd0, in_ready_o}, 64'd1);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; the block SHALL support any multiple of 16 that is at least 16.
REQ-002 Parameter NREG, default 32, number of architectural registers addressed; address width AW = $clog2(NREG).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid_i  input  1  operation request.
REQ-006 in_ready_o  output  1  block can accept a request this cycle.
REQ-007 op_i  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 BSW, 6 BSH, 7 HSW, 8 DIVU, 9 DIV, 10 SATADD, 11 SATSUB, 12-15 illegal.
REQ-008 dest_i  input  AW  primary destination register number (result, quotient).
REQ-009 dest2_i  input  AW  secondary destination register number (remainder, DIV/DIVU only).
REQ-010 src1_i  input  XLEN  operand 1.
REQ-011 src2_i  input  XLEN  operand 2.
REQ-012 cin_i  input  1  carry-in, ADD only.
REQ-013 wb_valid_o  output  1  one-cycle write-back strobe.
REQ-014 wb_addr_o  output  AW  write-back register number.
REQ-015 wb_data_o  output  XLEN  write-back data.
REQ-016 psw_o  output  5  flags: [4] SAT (sticky), [3] CY, [2] OV, [1] S, [0] Z.
REQ-017 illegal_o  output  1  one-cycle pulse for an undecoded opcode.

Function
REQ-018 A request SHALL be accepted on a rising edge where in_valid_i and in_ready_o are both 1; in_ready_o SHALL be 1 exactly when the FSM is in IDLE.
REQ-019 The FSM states SHALL be IDLE, DIV_RUN, WB_Q and WB_R; non-divide ops SHALL stay in IDLE, so back-to-back acceptance every cycle is allowed.
REQ-020 Non-divide ops SHALL have a latency of 1: wb_valid_o, wb_addr_o = dest_i, wb_data_o and psw_o SHALL be registered on the edge that accepts the op.
REQ-021 ADD: result = src2+src1+cin_i; CY = carry out; OV = signed overflow; S = result MSB; Z = (result == 0).
REQ-022 SUB: result = src2-src1; CY = borrow; OV = signed overflow; S and Z as for ADD.
REQ-023 AND, OR and XOR: bitwise result; OV=0; CY unchanged; S and Z from the result.
REQ-024 BSW: full byte reversal of src2; CY = any result byte zero; Z = (result == 0).
REQ-025 BSH: bytes swapped within each halfword of src2; CY = either byte of the low halfword zero; Z = (low halfword == 0).
REQ-026 HSW: halfword order of src2 reversed; CY = any result halfword zero; Z = (result == 0).
REQ-027 BSW, BSH and HSW SHALL set OV=0 and S = result MSB.
REQ-028 DIV/DIVU: src2/src1 via restoring radix-2, one quotient bit per cycle. IDLE→DIV_RUN SHALL last XLEN cycles, then WB_Q (write dest_i = quotient, flags update), then WB_R (write dest2_i = remainder), then IDLE; in_ready_o = 0 from acceptance until IDLE.
REQ-029 DIV signed: quotient truncates toward zero; remainder takes the sign of the dividend; S and Z come from the quotient; OV = 0 except as REQ-030/031.
REQ-030 Divide by zero: the FSM SHALL NOT enter DIV_RUN; the result SHALL appear 1 cycle later with no write-back, OV=1 and other flags unchanged.
REQ-031 DIV of most-negative by -1: quotient = most-negative, remainder = 0, OV=1, both write-backs performed with normal timing.
REQ-032 Illegal opcode: illegal_o SHALL pulse 1 cycle later, with no write-back and psw_o unchanged.
REQ-033 A write-back whose address is 0 SHALL be suppressed (wb_valid_o = 0); the flags SHALL still update.
REQ-034 If dest_i == dest2_i on a divide, both strobes SHALL occur; the remainder wins.
REQ-035 in_valid_i SHALL be ignored while in_ready_o = 0; operands SHALL be captured at acceptance.

Reset
REQ-036 On rst_n=0 the block SHALL go to IDLE, with wb_valid_o=0, wb_addr_o=0, wb_data_o=0, psw_o=0 and illegal_o=0; in_ready_o=1 after release.
REQ-037 Reset during DIV_RUN, WB_Q or WB_R SHALL abort the divide with no further write-back.

Configuration
REQ-038 Macro EXEC_UNIT_SAT_EN: when defined, SATADD/SATSUB SHALL compute as ADD (cin=0) / SUB, clamp to the signed max/min on overflow, set SAT=1 (sticky until reset) on clamp, with other flags as for ADD/SUB on the unclamped result.
REQ-039 When EXEC_UNIT_SAT_EN is undefined, opcodes 10 and 11 SHALL be illegal per REQ-032 and SAT SHALL read 0.

Verification (XLEN=32)
REQ-040 ADD src2=0x7FFFFFFF, src1=1, cin=0, dest=5 -> next cycle wb 5 ← 0x80000000; psw CY=0, OV=1, S=1, Z=0.
REQ-041 SUB src2=0, src1=1, dest=6 -> wb 6 ← 0xFFFFFFFF; CY=1, S=1, OV=0, Z=0.
REQ-042 DIV src2=0xFFFFFFF9, src1=2, dest=3, dest2=4 -> in_ready 0 for 34 cycles; wb 3 ← 0xFFFFFFFD at cycle 33, wb 4 ← 0xFFFFFFFF at cycle 34; S=1.
REQ-043 DIVU src1=0 -> no wb, OV=1 one cycle later, in_ready stays 1; rst_n pulse at DIV_RUN cycle 10 -> no wb, all outputs 0.
REQ-044 SATADD 0x7FFFFFFF+1 -> with macro: wb 0x7FFFFFFF, SAT=1; without macro: illegal_o pulse, no wb.
